digital_clock_core: RTL

Parametrised 24-hour timekeeper that derives its own one-second tick from the system clock, with run/stop, synchronous time load, a 12/24-hour display mode and an hh:mm alarm. It is the successor to the fixed 1 Hz-clocked counter. It sits between the board clock and the display drivers. It provides binary time fields for software and 14-bit seven-segment codes for the hour, minute and second digit pairs.

---
 rtl/clock_pkg.sv | 38 +++
 rtl/digital_clock_core_tick_gen.sv | 33 +++
 rtl/sevenSegment.sv | 37 +++
 rtl/digital_clock_core.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared widths, limits, time record and helpers for the digital clock core.
package clock_pkg;

    localparam int HRS_W = 5;
    localparam int MIN_W = 6;
    localparam int SEC_W = 6;
    localparam int SEG_W = 14;

    localparam logic [HRS_W-1:0] MAX_HRS = 5'd23;
    localparam logic [MIN_W-1:0] MAX_MIN = 6'd59;
    localparam logic [SEC_W-1:0] MAX_SEC = 6'd59;

    typedef struct packed {
        logic [HRS_W-1:0] hrs;
        logic [MIN_W-1:0] min;
        logic [SEC_W-1:0] sec;
    } clock_time_t;

    // 24-hour value to the hour shown on a 12-hour display (0 reads as 12).
    function automatic logic [HRS_W-1:0] to_12h(input logic [HRS_W-1:0] hrs);
        logic [HRS_W-1:0] disp;
        if (hrs == 5'd0) begin
            disp = 5'd12;
        end else if (hrs > 5'd12) begin
            disp = hrs - 5'd12;
        end else begin
            disp = hrs;
        end
        return disp;
    endfunction

    function automatic logic time_in_range(input logic [HRS_W-1:0] hrs,
                                           input logic [MIN_W-1:0] min,
                                           input logic [SEC_W-1:0] sec);
        return (hrs <= MAX_HRS) && (min <= MAX_MIN) && (sec <= MAX_SEC);
    endfunction

endpackage

// File: rtl/digital_clock_core_tick_gen.sv
// Prescaler producing a one-cycle tick every TICK_DIV running cycles.
module tick_gen #(
    parameter int TICK_DIV = 50_000_000,
    parameter int DIV_W    = $clog2(TICK_DIV)
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic clear,
    output logic tick
);

    localparam logic [DIV_W-1:0] LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [DIV_W-1:0] ONE  = DIV_W'(1);

    logic [DIV_W-1:0] r_cnt;

    // Count while running; a clear restarts the second from zero even when stopped.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (clear) begin
            r_cnt <= '0;
        end else if (run) begin
            r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + ONE;
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign tick = run && (r_cnt == LAST);

endmodule

// File: rtl/sevenSegment.sv
// Two-digit decimal seven-segment encoder: {tens, units}, each gfedcba, active high.
module sevenSegment
    import clock_pkg::*;
(
    input  logic [5:0]       i_value,
    output logic [SEG_W-1:0] o_code
);

    function automatic logic [6:0] digit_seg(input logic [3:0] d);
        logic [6:0] seg;
        case (d)
            4'd0:    seg = 7'h3F;
            4'd1:    seg = 7'h06;
            4'd2:    seg = 7'h5B;
            4'd3:    seg = 7'h4F;
            4'd4:    seg = 7'h66;
            4'd5:    seg = 7'h6D;
            4'd6:    seg = 7'h7D;
            4'd7:    seg = 7'h07;
            4'd8:    seg = 7'h7F;
            4'd9:    seg = 7'h6F;
            default: seg = 7'h00;
        endcase
        return seg;
    endfunction

    logic [3:0] w_tens;
    logic [3:0] w_units;

    // Split into decimal digits and encode each.
    always_comb begin
        w_tens  = 4'(i_value / 6'd10);
        w_units = 4'(i_value % 6'd10);
        o_code  = {digit_seg(w_tens), digit_seg(w_units)};
    end

endmodule

// File: rtl/digital_clock_core.sv
// 24-hour timekeeper with internal prescaler, range-checked load, hh:mm alarm
// and 12/24-hour seven-segment display codes.
module digital_clock_core
    import clock_pkg::*;
#(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic             load,
    input  logic [HRS_W-1:0] set_hrs,
    input  logic [MIN_W-1:0] set_min,
    input  logic [SEC_W-1:0] set_sec,
    input  logic             alarm_wr,
    input  logic [HRS_W-1:0] alarm_hrs,
    input  logic [MIN_W-1:0] alarm_min,
    input  logic             alarm_en,
    input  logic             alarm_ack,
    input  logic             mode_12h,
    output logic [HRS_W-1:0] hours,
    output logic [MIN_W-1:0] minutes,
    output logic [SEC_W-1:0] seconds,
    output logic             pm,
    output logic             sec_tick,
    output logic             alarm,
    output logic             load_err,
    output logic [SEG_W-1:0] hrsCode,
    output logic [SEG_W-1:0] minCode,
    output logic [SEG_W-1:0] secCode
);

    localparam int DIV_W = $clog2(TICK_DIV);

    clock_time_t      r_time;
    clock_time_t      w_adv;
    clock_time_t      w_time_nxt;
    logic             r_pm;
    logic             r_sec_tick;
    logic             r_load_err;
    logic             r_alarm;
    logic [HRS_W-1:0] r_alarm_hrs;
    logic [MIN_W-1:0] r_alarm_min;
    logic             w_tick;
    logic             w_load_ok;
    logic             w_alarm_wr_ok;
    logic             w_tick_eff;
    logic             w_alarm_set;
    logic [HRS_W-1:0] w_disp_hrs;

    assign w_load_ok     = load && time_in_range(set_hrs, set_min, set_sec);
    assign w_alarm_wr_ok = alarm_wr && time_in_range(alarm_hrs, alarm_min, 6'd0);
    // A valid load restarts the second, so a coincident tick is dropped.
    assign w_tick_eff    = w_tick && !w_load_ok;

    tick_gen #(
        .TICK_DIV (TICK_DIV),
        .DIV_W    (DIV_W)
    ) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .run   (run),
        .clear (w_load_ok),
        .tick  (w_tick)
    );

    // One-second advance with seconds/minutes/hours carry and day wrap.
    always_comb begin
        w_adv = r_time;
        if (r_time.sec == MAX_SEC) begin
            w_adv.sec = '0;
            if (r_time.min == MAX_MIN) begin
                w_adv.min = '0;
                if (r_time.hrs == MAX_HRS) begin
                    w_adv.hrs = '0;
                end else begin
                    w_adv.hrs = r_time.hrs + 5'd1;
                end
            end else begin
                w_adv.min = r_time.min + 6'd1;
            end
        end else begin
            w_adv.sec = r_time.sec + 6'd1;
        end
    end

    // Next time: load beats tick, otherwise hold.
    always_comb begin
        w_time_nxt = r_time;
        if (w_load_ok) begin
            w_time_nxt = '{hrs: set_hrs, min: set_min, sec: set_sec};
        end else if (w_tick) begin
            w_time_nxt = w_adv;
        end else begin
            w_time_nxt = r_time;
        end
    end

    assign w_alarm_set = w_tick_eff && alarm_en &&
                         (w_adv.hrs == r_alarm_hrs) && (w_adv.min == r_alarm_min) &&
                         (w_adv.sec == 6'd0);

    // Time, pm and the one-cycle status pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_time     <= '0;
            r_pm       <= 1'b0;
            r_sec_tick <= 1'b0;
            r_load_err <= 1'b0;
        end else begin
            r_time     <= w_time_nxt;
            r_pm       <= (w_time_nxt.hrs >= 5'd12);
            r_sec_tick <= w_tick_eff;
            r_load_err <= (load && !w_load_ok) || (alarm_wr && !w_alarm_wr_ok);
        end
    end

    // Alarm compare register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_alarm_hrs <= '0;
            r_alarm_min <= '0;
        end else if (w_alarm_wr_ok) begin
            r_alarm_hrs <= alarm_hrs;
            r_alarm_min <= alarm_min;
        end else begin
            r_alarm_hrs <= r_alarm_hrs;
            r_alarm_min <= r_alarm_min;
        end
    end

    // Latched alarm flag; a set outranks a same-cycle acknowledge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_alarm <= 1'b0;
        end else if (!alarm_en) begin
            r_alarm <= 1'b0;
        end else if (w_alarm_set) begin
            r_alarm <= 1'b1;
        end else if (alarm_ack) begin
            r_alarm <= 1'b0;
        end else begin
            r_alarm <= r_alarm;
        end
    end

    assign hours    = r_time.hrs;
    assign minutes  = r_time.min;
    assign seconds  = r_time.sec;
    assign pm       = r_pm;
    assign sec_tick = r_sec_tick;
    assign alarm    = r_alarm;
    assign load_err = r_load_err;

    assign w_disp_hrs = mode_12h ? to_12h(r_time.hrs) : r_time.hrs;

    sevenSegment u_seg_hrs (.i_value ({1'b0, w_disp_hrs}), .o_code (hrsCode));
    sevenSegment u_seg_min (.i_value (r_time.min),         .o_code (minCode));
    sevenSegment u_seg_sec (.i_value (r_time.sec),         .o_code (secCode));

endmodule
